crt_scanner: RTL



---
 rtl/crt_scanner_if.sv | 12 +
 rtl/crt_scanner.sv | 138 +++++++++++++
 2 files changed

// File: rtl/crt_scanner_if.sv
// Pixel stream from the scanner to the display/framebuffer writer.
// The scanner holds valid and pixel data steady until the writer takes the pixel.
interface crt_scanner_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_on;

    modport master (output pix_valid, pix_x, pix_y, pix_on, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_on, output pix_ready);
endinterface

// File: rtl/crt_scanner.sv
// CRT scanner: runs the X-delta program from a combinational ROM, one entry per accepted pixel.
// Emits the raster stream, tracks X and accumulates signal strength at the sampled cycles.
module crt_scanner #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int X_WIDTH    = 16,
    parameter int SUM_WIDTH  = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    output logic [ADDR_BITS-1:0]        o_rom_addr,
    input  logic [DATA_WIDTH-1:0]       i_rom_data,
    input  logic [7:0]                  i_screen_w,
    input  logic [7:0]                  i_screen_h,
    crt_scanner_if.master               pix,
    output logic signed [X_WIDTH-1:0]   o_x_reg,
    output logic signed [SUM_WIDTH-1:0] o_sig_sum,
    output logic                        o_busy,
    output logic                        o_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ADDR_BITS:0]           r_idx;
    logic [7:0]                   r_col;
    logic [7:0]                   r_row;
    logic [7:0]                   r_w;
    logic [15:0]                  r_total;
    logic signed [X_WIDTH-1:0]    r_x;
    logic signed [SUM_WIDTH-1:0]  r_sum;

    logic                         w_run;
    logic                         w_start_run;
    logic                         w_fire;
    logic                         w_last;
    logic                         w_sample;
    logic [ADDR_BITS:0]           w_n;
    logic [15:0]                  w_total_in;
    logic signed [X_WIDTH-1:0]    w_delta;
    logic signed [SUM_WIDTH-1:0]  w_n_s;
    logic signed [SUM_WIDTH-1:0]  w_x_s;
    logic signed [SUM_WIDTH-1:0]  w_prod;
    logic signed [X_WIDTH:0]      w_diff;

    assign w_run       = (r_state == S_RUN);
    assign w_start_run = !w_run && i_start;
    assign w_fire      = w_run && pix.pix_ready;
    assign w_n         = r_idx + 1'b1;
    assign w_last      = (32'(w_n) == 32'(r_total));
    assign w_total_in  = 16'(i_screen_w) * 16'(i_screen_h);

    assign w_delta = {{(X_WIDTH-DATA_WIDTH){i_rom_data[DATA_WIDTH-1]}}, i_rom_data};

    // n is a positive cycle number, X is signed; both widened before the multiply
    // so the product is the true signed value modulo 2^SUM_WIDTH.
    assign w_n_s  = {{(SUM_WIDTH-ADDR_BITS-1){1'b0}}, w_n};
    assign w_x_s  = {{(SUM_WIDTH-X_WIDTH){r_x[X_WIDTH-1]}}, r_x};
    assign w_prod = w_n_s * w_x_s;

    always_comb begin
        w_sample = 1'b0;
        case (32'(w_n))
            32'd20, 32'd60, 32'd100, 32'd140, 32'd180, 32'd220: w_sample = 1'b1;
            default: w_sample = 1'b0;
        endcase
    end

    // Sprite hit test: X - col in {-1,0,1}, one extra bit so the difference cannot wrap.
    assign w_diff = {r_x[X_WIDTH-1], r_x} - {{(X_WIDTH-7){1'b0}}, r_col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        pix.pix_valid = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                o_done = (r_state == S_DONE);
                if (i_start) w_state_nxt = (w_total_in == 16'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                pix.pix_valid = 1'b1;
                o_busy        = 1'b1;
                if (pix.pix_ready && w_last) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_w     <= '0;
            r_total <= '0;
            r_x     <= X_WIDTH'(1);
            r_sum   <= '0;
        end else if (w_start_run) begin
            r_idx   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_w     <= i_screen_w;
            r_total <= w_total_in;
            r_x     <= X_WIDTH'(1);
            r_sum   <= '0;
        end else if (w_fire) begin
            if (w_sample) r_sum <= r_sum + w_prod;
            r_x   <= r_x + w_delta;
            r_idx <= w_n;
            if (w_last) begin
                r_col <= '0;
                r_row <= '0;
            end else if (r_col == r_w - 8'd1) begin
                r_col <= '0;
                r_row <= r_row + 8'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    assign o_rom_addr = r_idx[ADDR_BITS-1:0];
    assign pix.pix_x  = r_col;
    assign pix.pix_y  = r_row;
    assign pix.pix_on = w_run && ((w_diff == '1) || (w_diff == '0) || (w_diff == (X_WIDTH+1)'(1)));
    assign o_x_reg    = r_x;
    assign o_sig_sum  = r_sum;

endmodule
